mips_avalon_mem_ctrl: RTL and testbench

- Multi-cycle Avalon-MM bus master that sits between the MIPS CPU core datapath and the single memory bus.
- Accepts one byte, halfword or word load/store request at a time from the core.
- Generates word-aligned bus transactions with the correct byteenable and lane placement.
- Honours waitrequest, and returns sign- or zero-extended load data or an error response (misalignment or bus timeout).

---
 rtl/mips_avalon_mem_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_avalon_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_mem_ctrl.sv
// mips_avalon_mem_ctrl
//   Multi-cycle Avalon-MM master between the MIPS core datapath and the memory bus.
//   It accepts one byte/half/word load or store at a time and issues one word-aligned
//   bus transaction for it. Store data is replicated onto the byte lanes and the lanes
//   are selected with byteenable. Load data is taken from the selected lane(s) and then
//   sign- or zero-extended. Misaligned requests and bus timeouts end with an error response.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready      core request handshake
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                  request fields, latched when the request is accepted
//   rsp_valid / rsp_err /
//   rsp_rdata                  one-cycle completion pulse, error flag and extended load data
//   address, read, write,
//   writedata, byteenable      Avalon-MM master command outputs (all registered)
//   waitrequest, readdata      Avalon-MM slave responses
module mips_avalon_mem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort happens on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic                    sgn_q, sgn_d;
  logic [1:0]              lo_q, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [31:0]             writedata_q, writedata_d;
  logic [3:0]              byteenable_q, byteenable_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;

  // Lane placement for the incoming request
  logic [1:0]  in_lane;
  logic        in_half;
  logic        in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  always_comb begin
    in_lane       = BIG_ENDIAN ? (2'd3 - req_addr[1:0]) : req_addr[1:0];
    in_half       = BIG_ENDIAN ? ~req_addr[1] : req_addr[1];
    in_misaligned = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_size)
      2'b00: begin
        in_be    = 4'b0001 << in_lane;
        in_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        in_be    = in_half ? 4'b1100 : 4'b0011;
        in_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = req_wdata;
      end
    endcase
  end

  // Load extraction from the latched offset/size of the accepted request
  logic [1:0]  ld_lane;
  logic        ld_half;
  logic [7:0]  ld_byte;
  logic [15:0] ld_hword;
  logic [31:0] ld_data;

  always_comb begin
    ld_lane = BIG_ENDIAN ? (2'd3 - lo_q) : lo_q;
    ld_half = BIG_ENDIAN ? ~lo_q[1] : lo_q[1];
    case (ld_lane)
      2'd0:    ld_byte = readdata[7:0];
      2'd1:    ld_byte = readdata[15:8];
      2'd2:    ld_byte = readdata[23:16];
      default: ld_byte = readdata[31:24];
    endcase
    ld_hword = ld_half ? readdata[31:16] : readdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sgn_q & ld_hword[15]}}, ld_hword};
      default: ld_data = readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d   = req_write;
          size_d = req_size;
          sgn_d  = req_signed;
          lo_d   = req_addr[1:0];
          cnt_d  = '0;
          if (in_misaligned) begin
            // Rejected without touching the bus
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d      = ACCESS;
            read_d       = ~req_write;
            write_d      = req_write;
            address_d    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            writedata_d  = in_wdata;
            byteenable_d = in_be;
          end
        end
      end

      ACCESS: begin
        if (!waitrequest) begin
          state_d     = RESP;
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? 32'h0 : ld_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
            state_d     = RESP;
            read_d      = 1'b0;
            write_d     = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      RESP: begin
        state_d     = IDLE;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      lo_q         <= 2'b00;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_avalon_mem_ctrl.sv
// Bench for mips_avalon_mem_ctrl: instance 0 is little-endian with a 4-cycle timeout,
// instance 1 is big-endian with the timeout disabled. A byte-oriented reference model
// predicts the bus command, lane mask, store data and extended load result.
module tb_mips_avalon_mem_ctrl;

  logic        clk;
  logic        reset       [2];
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_write   [2];
  logic [1:0]  req_size    [2];
  logic        req_signed  [2];
  logic [31:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic        rsp_valid   [2];
  logic        rsp_err     [2];
  logic [31:0] rsp_rdata   [2];
  logic [31:0] address     [2];
  logic        read        [2];
  logic        write       [2];
  logic        waitrequest [2];
  logic [31:0] writedata   [2];
  logic [3:0]  byteenable  [2];
  logic [31:0] readdata    [2];

  int checks   = 0;
  int failures = 0;

  mips_avalon_mem_ctrl #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(4)) dut_le (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]),
    .rsp_rdata(rsp_rdata[0]), .address(address[0]), .read(read[0]), .write(write[0]),
    .waitrequest(waitrequest[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
    .readdata(readdata[0])
  );

  mips_avalon_mem_ctrl #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0)) dut_be (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]),
    .rsp_rdata(rsp_rdata[1]), .address(address[1]), .read(read[1]), .write(write[1]),
    .waitrequest(waitrequest[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
    .readdata(readdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int timeout_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Lane holding the byte at memory address a
  function automatic int lane_of(input int d, input logic [31:0] a);
    int lo;
    lo = int'(a[1:0]);
    return (d == 1) ? 3 - lo : lo;
  endfunction

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input int d, input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < nbytes(sz); i++) m[lane_of(d, a + i)] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  // Assemble the loaded value byte by byte in memory order, then extend
  function automatic logic [31:0] model_load(input int d, input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v, b;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = (rd >> (8 * lane_of(d, a + i))) & 32'hFF;
      v = v | (b << (8 * ((d == 1) ? (n - 1 - i) : i)));
    end
    if (sg && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  // One complete transaction; entered and left #1 after a rising edge with the DUT idle.
  task automatic run_txn(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int nwait);
    bit          mis, exp_err;
    int          ncyc;
    logic [31:0] exp_rdata;
    mis = is_misaligned(sz, a);
    check_eq("req_ready_idle", 32'(req_ready[d]), 32'h1);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    @(posedge clk); #1;
    // Scramble the request fields so the DUT must rely on its latched copy
    req_valid[d]  = 1'b0;
    req_write[d]  = 1'($urandom);
    req_size[d]   = 2'($urandom);
    req_signed[d] = 1'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    if (mis) begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
      check_eq("mis_read", 32'(read[d]), 32'h0);
      check_eq("mis_write", 32'(write[d]), 32'h0);
    end else begin
      if (timeout_of(d) != 0 && nwait >= timeout_of(d)) begin
        ncyc      = timeout_of(d);
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
      end else begin
        ncyc      = nwait + 1;
        exp_err   = 1'b0;
        exp_rdata = wr ? 32'h0 : model_load(d, sz, sg, a, rd);
      end
      for (int c = 0; c < ncyc; c++) begin
        check_eq("bus_read", 32'(read[d]), 32'(!wr));
        check_eq("bus_write", 32'(write[d]), 32'(wr));
        check_eq("bus_address", address[d], a & 32'hFFFF_FFFC);
        check_eq("bus_byteenable", 32'(byteenable[d]), 32'(model_be(d, sz, a)));
        if (wr) check_eq("bus_writedata", writedata[d], model_wdata(sz, wd));
        check_eq("rsp_valid_busy", 32'(rsp_valid[d]), 32'h0);
        check_eq("req_ready_busy", 32'(req_ready[d]), 32'h0);
        waitrequest[d] = (c < nwait);
        readdata[d]    = (c < nwait) ? $urandom : rd;
        @(posedge clk); #1;
      end
      waitrequest[d] = 1'b0;
      readdata[d]    = $urandom;
      check_eq("bus_read_drop", 32'(read[d]), 32'h0);
      check_eq("bus_write_drop", 32'(write[d]), 32'h0);
    end
    check_eq("rsp_valid", 32'(rsp_valid[d]), 32'h1);
    check_eq("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
    check_eq("rsp_rdata", rsp_rdata[d], exp_rdata);
    check_eq("req_ready_resp", 32'(req_ready[d]), 32'h0);
    $display("txn dut%0d wr=%0d size=%0d signed=%0d addr=%h wdata=%h rd=%h wait=%0d -> err=%0d rdata=%h",
             d, wr, sz, sg, a, wd, rd, nwait, exp_err, exp_rdata);
    @(posedge clk); #1;
    check_eq("rsp_valid_pulse", 32'(rsp_valid[d]), 32'h0);
    check_eq("req_ready_after", 32'(req_ready[d]), 32'h1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      waitrequest[d] = 1'b0; readdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_req_ready", 32'(req_ready[d]), 32'h1);
      check_eq("rst_rsp_valid", 32'(rsp_valid[d]), 32'h0);
      check_eq("rst_rsp_err", 32'(rsp_err[d]), 32'h0);
      check_eq("rst_rsp_rdata", rsp_rdata[d], 32'h0);
      check_eq("rst_read", 32'(read[d]), 32'h0);
      check_eq("rst_write", 32'(write[d]), 32'h0);
      check_eq("rst_address", address[d], 32'h0);
      check_eq("rst_writedata", writedata[d], 32'h0);
      check_eq("rst_byteenable", 32'(byteenable[d]), 32'h0);
      reset[d] = 1'b0;
    end
    @(posedge clk); #1;

    // Directed cases
    run_txn(0, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    run_txn(0, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 3);
    run_txn(1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h9A00_0000, 0);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h1234_5678, 0);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 10);
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 9);
    run_txn(1, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'h0, 1);

    // Reset while a read is stalled
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'b10; req_addr[0] = 32'h40;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    waitrequest[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_read", 32'(read[0]), 32'h1);
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    waitrequest[0] = 1'b0;
    check_eq("rst_mid_read", 32'(read[0]), 32'h0);
    check_eq("rst_mid_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check_eq("rst_mid_ready", 32'(req_ready[0]), 32'h1);
    run_txn(0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0, 0);

    // Randomized traffic on both instances
    for (int n = 0; n < 120; n++) begin
      int          d, nw;
      logic [1:0]  sz;
      logic [31:0] a;
      d  = n % 2;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'h1);
      nw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      run_txn(d, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, nw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
